fetch_queue: RTL and testbench

- Parametrised instruction prefetch buffer for the pipelined core. Sits between the PC/instruction-memory interface and decode.
- Owns the fetch PC and issues sequential instruction-memory reads. Buffers up to DEPTH instructions with their PCs and presents them to decode with a valid/ready handshake.
- Flushes on branch/jump redirect and restarts at the target PC with no issue bubble.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, issues sequential reads, queues {inst, pc} for decode.
// Optional IFQ_BYPASS_EN: an empty queue forwards the arriving response straight to decode.
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic                         im_req_o,
  output logic [ADDR_WIDTH-1:0]        im_addr_o,
  input  logic [DATA_WIDTH-1:0]        im_dout_i,
  input  logic                         redirect_i,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc_i,
  output logic                         inst_valid_o,
  output logic [DATA_WIDTH-1:0]        inst_o,
  output logic [ADDR_WIDTH-1:0]        inst_pc_o,
  input  logic                         inst_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int STRIDE = DATA_WIDTH / 8;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int PW     = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_req_d1;
  logic [ADDR_WIDTH-1:0] r_pc_d1;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_last_data;
  logic [ADDR_WIDTH-1:0] r_last_pc;
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_pc   [DEPTH];

  logic [CW:0]           w_fill;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_nonempty;
  logic                  w_bypass;
  logic                  w_take;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The in-flight response already owns a slot, so it is counted against free space.
  assign w_fill     = {1'b0, r_count} + (CW + 1)'(r_req_d1);
  assign w_issue    = ~rst_i & (redirect_i | (w_fill < (CW + 1)'(DEPTH)));
  assign w_target   = redirect_pc_i & ~ADDR_WIDTH'(STRIDE - 1);
  assign w_addr     = redirect_i ? w_target : r_fetch_pc;
  assign w_nonempty = (r_count != '0);

`ifdef IFQ_BYPASS_EN
  assign w_bypass = ~w_nonempty & r_req_d1 & ~redirect_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign im_req_o     = w_issue;
  assign im_addr_o    = w_addr;
  assign inst_valid_o = ~rst_i & ~redirect_i & (w_nonempty | w_bypass);
  assign inst_o       = w_nonempty ? r_mem_data[r_rd_ptr] : (w_bypass ? im_dout_i : r_last_data);
  assign inst_pc_o    = w_nonempty ? r_mem_pc[r_rd_ptr]   : (w_bypass ? r_pc_d1   : r_last_pc);
  assign count_o      = r_count;

  assign w_take = inst_valid_o & inst_ready_i;
  assign w_pop  = w_take & w_nonempty;
  // A bypassed response consumed by decode never enters storage.
  assign w_push = r_req_d1 & ~redirect_i & ~(w_take & w_bypass);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc  <= RESET_PC;
      r_req_d1    <= 1'b0;
      r_pc_d1     <= '0;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_last_data <= '0;
      r_last_pc   <= '0;
    end else begin
      r_req_d1 <= w_issue;
      if (w_issue) begin
        r_pc_d1    <= w_addr;
        r_fetch_pc <= w_addr + ADDR_WIDTH'(STRIDE);
      end
      if (w_take) begin
        r_last_data <= inst_o;
        r_last_pc   <= inst_pc_o;
      end
      if (redirect_i) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= im_dout_i;
      r_mem_pc[r_wr_ptr]   <= r_pc_d1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based behavioural model.
module tb_fetch_queue;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] RPC   = 32'h0;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          im_req_o;
  logic [AW-1:0] im_addr_o;
  logic [DW-1:0] im_dout_i = '0;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_pc_i = '0;
  logic          inst_valid_o;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_pc_o;
  logic          inst_ready_i = 1'b0;
  logic [CW-1:0] count_o;

  fetch_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .im_req_o(im_req_o), .im_addr_o(im_addr_o),
    .im_dout_i(im_dout_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  bit          m_inflight = 1'b0;
  logic [31:0] m_inflight_pc = '0;
  logic [31:0] m_fetch_pc = RPC;
  logic [31:0] pc_log[$];
  logic [31:0] dat_log[$];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] log_at(input bit is_pc, input int i);
    if (is_pc) return (pc_log.size() > i) ? pc_log[i] : 'x;
    return (dat_log.size() > i) ? dat_log[i] : 'x;
  endfunction

  // One clock: drive inputs, compare every output against the model, then advance the model.
  task automatic cyc(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          e_req, e_valid, byp, consumed;
    logic [31:0] e_addr, dout;
    ent_t        head;
    int          e_count;
    dout    = m_inflight ? mem_word(m_inflight_pc) : $urandom();
    e_count = m_q.size();
    byp     = BYP && (m_q.size() == 0) && m_inflight && !redir;
    e_req   = !rst && (redir || (m_q.size() + int'(m_inflight) < DEPTH));
    e_addr  = redir ? (rpc & ~32'h3) : m_fetch_pc;
    e_valid = !rst && !redir && (m_q.size() != 0 || byp);
    if (m_q.size() != 0) head = m_q[0];
    else head = '{d: dout, pc: m_inflight_pc};

    rst_i = rst; redirect_i = redir; redirect_pc_i = rpc; inst_ready_i = rdy; im_dout_i = dout;
    @(negedge clk_i);
    chk("im_req", im_req_o, e_req);
    if (e_req) chk("im_addr", im_addr_o, e_addr);
    chk("inst_valid", inst_valid_o, e_valid);
    if (e_valid) begin
      chk("inst", inst_o, head.d);
      chk("inst_pc", inst_pc_o, head.pc);
    end
    if (!rst) chk("count", count_o, e_count);
    if (!rst && inst_valid_o && inst_ready_i) begin
      pc_log.push_back(inst_pc_o);
      dat_log.push_back(inst_o);
    end
    @(posedge clk_i);
    if (rst) begin
      m_q.delete(); m_inflight = 1'b0; m_fetch_pc = RPC;
    end else begin
      if (redir) m_q.delete();
      else begin
        consumed = 1'b0;
        if (e_valid && rdy) begin
          if (m_q.size() != 0) void'(m_q.pop_front());
          else consumed = 1'b1;
        end
        if (m_inflight && !consumed) m_q.push_back('{d: dout, pc: m_inflight_pc});
      end
      m_inflight = e_req;
      if (e_req) begin
        m_inflight_pc = e_addr;
        m_fetch_pc    = e_addr + 32'd4;
      end
    end
    #1;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, rdy);
  endtask

  task automatic clear_logs();
    pc_log.delete();
    dat_log.delete();
  endtask

  initial begin
    int found;
    #1;
    // Reset release, sequential stream with decode always ready
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_count", count_o, 0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_inst_pc", inst_pc_o, 0);
    clear_logs();
    run(6, 1'b1);
    chk("seq_pc0", log_at(1, 0), 32'h0);
    chk("seq_pc1", log_at(1, 1), 32'h4);
    chk("seq_pc2", log_at(1, 2), 32'h8);
    chk("seq_d0", log_at(0, 0), 32'h1000);
    chk("seq_d2", log_at(0, 2), 32'h1002);

    // Stall from reset fills the queue, then drain and sustained streaming
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    run(8, 1'b0);
    chk("full_count", count_o, DEPTH);
    chk("full_req", im_req_o, 0);
    chk("model_fetch_pc", m_fetch_pc, 32'h10);
    clear_logs();
    run(16, 1'b1);
    chk("drain_pc0", log_at(1, 0), 32'h0);
    chk("drain_pc3", log_at(1, 3), 32'hC);
    chk("drain_pc4", log_at(1, 4), 32'h10);
    for (int i = 1; i < pc_log.size(); i++) chk("stream_seq", pc_log[i], pc_log[i-1] + 32'd4);

    // Redirect with 3 entries queued and one in flight
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 20 && count_o != 3; i++) run(1, 1'b0);
    chk("reach_cnt3", count_o, 3);
    clear_logs();
    cyc(1'b0, 1'b1, 32'h200, 1'b1);
    chk("redir_count", count_o, 0);
    run(4, 1'b1);
    chk("redir_pc0", log_at(1, 0), 32'h200);
    chk("redir_pc1", log_at(1, 1), 32'h204);

    // Back-to-back redirects: last target wins
    run(2, 1'b0);
    clear_logs();
    cyc(1'b0, 1'b1, 32'h300, 1'b1);
    cyc(1'b0, 1'b1, 32'h400, 1'b1);
    run(4, 1'b1);
    chk("b2b_pc0", log_at(1, 0), 32'h400);
    found = 0;
    foreach (pc_log[i]) if (pc_log[i] == 32'h300) found++;
    chk("b2b_no_300", found, 0);

    // Address wrap, with low redirect bits ignored
    clear_logs();
    cyc(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    run(4, 1'b1);
    chk("wrap_pc0", log_at(1, 0), 32'hFFFF_FFFC);
    chk("wrap_pc1", log_at(1, 1), 32'h0);
    chk("wrap_d1", log_at(0, 1), 32'h1000);

    // Reset mid-stream
    run(3, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("midrst_count", count_o, 0);
    chk("midrst_valid", inst_valid_o, 0);
    clear_logs();
    run(4, 1'b1);
    chk("midrst_pc0", log_at(1, 0), RPC);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_red, r_rdy;
      r_rst = ($urandom_range(99) == 0);
      r_red = ($urandom_range(99) < 4);
      r_rdy = ($urandom_range(99) < 70);
      cyc(r_rst, r_red, $urandom(), r_rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
